// File: rtl/base_tfill_pkg.sv
// Shared types and helpers for the fill-level counter.
// Holds the next-count select encoding and the count-width helper.
package base_tfill_pkg;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_INC,
    OP_DEC,
    OP_BOTH
  } op_t;

  function automatic int enc_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/base_tdec_le.sv
// Little-endian thermometer decoder.
// Output bit i is set when the encoded count exceeds i.
module base_tdec_le #(
  parameter int dec_width = 4,
  parameter int enc_width = 3
) (
  input  logic [enc_width-1:0] enc,
  output logic [dec_width-1:0] therm
);

  // One compare per slot against the encoded count
  always_comb begin
    therm = '0;
    for (int i = 0; i < dec_width; i++) begin
      therm[i] = (int'(enc) > i);
    end
  end

endmodule

// File: rtl/base_tfill_cnt.sv
// Handshaked occupancy counter with registered thermometer mask.
// Define BASE_TFILL_CNT_PASS_EN to let a full counter take inc alongside dec.
module base_tfill_cnt
  import base_tfill_pkg::*;
#(
  parameter int width     = 4,
  parameter int enc_width = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  input  logic [enc_width-1:0] i_lim,
  input  logic                 i_inc_v,
  output logic                 i_inc_r,
  input  logic                 i_dec_v,
  output logic                 i_dec_r,
  output logic [enc_width-1:0] o_cnt,
  output logic [width-1:0]     o_therm,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam logic [enc_width-1:0] WMAX = enc_width'(width);
  localparam logic [enc_width-1:0] ONE  = enc_width'(1);

  logic [enc_width-1:0] eff_lim;
  logic [enc_width-1:0] cnt_nxt;
  logic [width-1:0]     therm_nxt;
  logic                 inc_acc;
  logic                 dec_acc;
  op_t                  op;

  // Clamp the run-time limit and derive the fill flags
  always_comb begin
    eff_lim = (i_lim > WMAX) ? WMAX : i_lim;
    o_full  = (o_cnt >= eff_lim);
    o_empty = (o_cnt == '0);
  end

  // Handshake readies and accepted events
  always_comb begin
    i_dec_r = ~o_empty;
`ifdef BASE_TFILL_CNT_PASS_EN
    i_inc_r = ~o_full | (i_dec_v & ~o_empty);
`else
    i_inc_r = ~o_full;
`endif
    inc_acc = i_inc_v & i_inc_r;
    dec_acc = i_dec_v & i_dec_r;
  end

  // Classify this cycle's accepted events
  always_comb begin
    op = OP_NOP;
    if (inc_acc && dec_acc) begin
      op = OP_BOTH;
    end else if (inc_acc) begin
      op = OP_INC;
    end else if (dec_acc) begin
      op = OP_DEC;
    end
  end

  // Next count; flush discards anything accepted this cycle
  always_comb begin
    cnt_nxt = o_cnt;
    if (i_flush) begin
      cnt_nxt = '0;
    end else begin
      unique case (op)
        OP_INC:  cnt_nxt = o_cnt + ONE;
        OP_DEC:  cnt_nxt = o_cnt - ONE;
        default: cnt_nxt = o_cnt;
      endcase
    end
  end

  base_tdec_le #(
    .dec_width(width),
    .enc_width(enc_width)
  ) u_dec (
    .enc   (cnt_nxt),
    .therm (therm_nxt)
  );

  // Count and mask update together so they never disagree
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_cnt   <= '0;
      o_therm <= '0;
    end else begin
      o_cnt   <= cnt_nxt;
      o_therm <= therm_nxt;
    end
  end

endmodule
